// File: rtl/board_io_cond.sv
// board_io_cond
//   Board-level front end sitting between the FPGA pins / PLL and the SoC.
//   - Synchronises PLL lock and produces a stretched, lock-qualified SoC reset.
//   - Synchronises and debounces a bank of switches, emitting per-channel
//     change strobes for the SoC GPIO inputs.
//
// Ports
//   clk_i         in   1         system clock (PLL output)
//   arst_n_i      in   1         asynchronous active-low board reset
//   pll_locked_i  in   1         PLL lock, asynchronous to clk_i
//   sw_i          in   SW_WIDTH  raw switch pins
//   soc_arst_o    out  1         active-high SoC reset (registered)
//   sw_o          out  SW_WIDTH  debounced switch state
//   sw_chg_o      out  SW_WIDTH  one-cycle pulse when the matching sw_o bit changes
//   tick_o        out  1         one-cycle debounce tick pulse
module board_io_cond #(
   parameter int SW_WIDTH    = 16,
   parameter int SYNC_STAGES = 2,
   parameter int RST_HOLD    = 1024,
   parameter int TICK_DIV    = 100000,
   parameter int DEB_TICKS   = 4
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                pll_locked_i,
   input  logic [SW_WIDTH-1:0] sw_i,
   output logic                soc_arst_o,
   output logic [SW_WIDTH-1:0] sw_o,
   output logic [SW_WIDTH-1:0] sw_chg_o,
   output logic                tick_o
);

   localparam int HCNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int TCNT_W = $clog2(TICK_DIV);
   localparam int DCNT_W = $clog2(DEB_TICKS + 1);

   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(RST_HOLD - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_TICKS - 1);

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Input synchronisers
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic [SW_WIDTH-1:0]    r_sw_sync [SYNC_STAGES];
   logic                   w_locked_s;
   logic [SW_WIDTH-1:0]    w_sw_s;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_lock_sync <= '0;
         for (int k = 0; k < SYNC_STAGES; k++) r_sw_sync[k] <= '0;
      end else begin
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
         r_sw_sync[0] <= sw_i;
         for (int k = 1; k < SYNC_STAGES; k++) r_sw_sync[k] <= r_sw_sync[k-1];
      end
   end

   assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
   assign w_sw_s     = r_sw_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Reset sequencer: RST -> HOLD (RST_HOLD cycles of stable lock) -> RUN.
   // Any loss of synchronised lock drops straight back to RST, and lock loss
   // wins over the HOLD->RUN step when both happen on the same edge.
   // ---------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_nxt;
   logic [HCNT_W-1:0]   r_hcnt;
   logic                r_soc_arst;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RST:  if (w_locked_s) w_state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (!w_locked_s)              w_state_nxt = ST_RST;
            else if (r_hcnt == HCNT_LAST) w_state_nxt = ST_RUN;
         end
         ST_RUN:  if (!w_locked_s) w_state_nxt = ST_RST;
         default: w_state_nxt = ST_RST;
      endcase
   end

   // Reset output is registered from the next state so it changes on the
   // very edge the sequencer enters or leaves RUN.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state    <= ST_RST;
         r_hcnt     <= '0;
         r_soc_arst <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_soc_arst <= (w_state_nxt != ST_RUN);
         if (r_state == ST_HOLD && w_state_nxt == ST_HOLD) r_hcnt <= r_hcnt + 1'b1;
         else                                              r_hcnt <= '0;
      end
   end

   assign soc_arst_o = r_soc_arst;

   // ---------------------------------------------------------------------
   // Free-running debounce tick prescaler
   // ---------------------------------------------------------------------
   logic [TCNT_W-1:0] r_tcnt;
   logic              w_tick;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i)           r_tcnt <= '0;
      else if (r_tcnt == TCNT_LAST) r_tcnt <= '0;
      else                     r_tcnt <= r_tcnt + 1'b1;
   end

   assign w_tick = (r_tcnt == TCNT_LAST);
   assign tick_o = w_tick;

   // ---------------------------------------------------------------------
   // Per-channel debouncer. A channel only changes after DEB_TICKS ticks
   // in a row where the synchronised input differs from the accepted state;
   // any return to agreement clears the count, rejecting bounces.
   // Only the board reset clears this state so switches survive PLL relock.
   // ---------------------------------------------------------------------
   logic [SW_WIDTH-1:0] r_sw;
   logic [SW_WIDTH-1:0] r_sw_chg;
   logic [DCNT_W-1:0]   r_dcnt [SW_WIDTH];

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_sw     <= '0;
         r_sw_chg <= '0;
         for (int i = 0; i < SW_WIDTH; i++) r_dcnt[i] <= '0;
      end else begin
         for (int i = 0; i < SW_WIDTH; i++) begin
            r_sw_chg[i] <= 1'b0;
            if (w_sw_s[i] == r_sw[i]) begin
               r_dcnt[i] <= '0;
            end else if (w_tick) begin
               if (r_dcnt[i] == DCNT_LAST) begin
                  r_sw[i]     <= w_sw_s[i];
                  r_sw_chg[i] <= 1'b1;
                  r_dcnt[i]   <= '0;
               end else begin
                  r_dcnt[i] <= r_dcnt[i] + 1'b1;
               end
            end
         end
      end
   end

   assign sw_o     = r_sw;
   assign sw_chg_o = r_sw_chg;

endmodule

// File: tb/tb_board_io_cond.sv
// Bench for board_io_cond with small parameters (SW_WIDTH=4, SYNC_STAGES=2,
// RST_HOLD=16, TICK_DIV=4, DEB_TICKS=3). Edges are counted from reset
// release; stimulus pushes expected reset transitions (value, edge) and
// expected switch-change events ({sw_chg, sw_o}) into queues that a
// negedge monitor pops whenever the DUT presents a change.
module tb_board_io_cond;

   localparam int SW = 4;

   logic          clk;
   logic          arst_n;
   logic          pll_locked;
   logic [SW-1:0] sw_in;
   logic          soc_arst;
   logic [SW-1:0] sw_out;
   logic [SW-1:0] sw_chg;
   logic          tick;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   logic [2*SW-1:0] exp_q[$];
   logic [32:0]     exp_rst_q[$];
   logic            prev_soc = 1'b1;

   board_io_cond #(
      .SW_WIDTH(SW), .SYNC_STAGES(2), .RST_HOLD(16), .TICK_DIV(4), .DEB_TICKS(3)
   ) dut (
      .clk_i(clk),
      .arst_n_i(arst_n),
      .pll_locked_i(pll_locked),
      .sw_i(sw_in),
      .soc_arst_o(soc_arst),
      .sw_o(sw_out),
      .sw_chg_o(sw_chg),
      .tick_o(tick)
   );

   // clock / reset-relative edge counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!arst_n) edge_n <= 0;
      else         edge_n <= edge_n + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_edge(input int n);
      while (edge_n < n) @(negedge clk);
   endtask

   task automatic wait_sw(input logic [SW-1:0] target, input string name);
      for (int i = 0; i < 30; i++) begin
         if (sw_out == target) break;
         @(negedge clk);
      end
      chk(name, 32'(sw_out), 32'(target));
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!arst_n) begin
         prev_soc = 1'b1;
      end else begin
         if (soc_arst !== prev_soc) begin
            if (exp_rst_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL soc_unexpected: soc_arst_o=%0b at edge %0d, no transition expected", soc_arst, edge_n);
            end else begin
               logic [32:0] e;
               e = exp_rst_q.pop_front();
               chk("soc_val", 32'(soc_arst), 32'(e[32]));
               chk("soc_edge", 32'(edge_n), e[31:0]);
            end
            prev_soc = soc_arst;
         end
         if (sw_chg != '0) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL chg_unexpected: sw_chg_o=%0b sw_o=%0b at edge %0d, no event expected", sw_chg, sw_out, edge_n);
            end else begin
               logic [2*SW-1:0] e2;
               e2 = exp_q.pop_front();
               chk("chg_event", 32'({sw_chg, sw_out}), 32'(e2));
            end
         end
         if (tick || (edge_n % 4 == 3))
            chk("tick_phase", 32'(tick), 32'(edge_n % 4 == 3));
      end
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      arst_n     = 1'b0;
      pll_locked = 1'b1;
      sw_in      = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_soc", 32'(soc_arst), 32'd1);
      chk("rst_sw_o", 32'(sw_out), 32'd0);
      chk("rst_sw_chg", 32'(sw_chg), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);

      // case 1: lock present before release, soc reset falls at edge 19
      exp_rst_q.push_back({1'b0, 32'd19});
      #1 arst_n = 1'b1;
      wait_edge(18); chk("c1_soc_e18", 32'(soc_arst), 32'd1);
      wait_edge(19); chk("c1_soc_e19", 32'(soc_arst), 32'd0);
      chk("c1_sw_o", 32'(sw_out), 32'd0);

      // case 2: 10-cycle lock drop in RUN
      wait_edge(30);
      pll_locked = 1'b0;
      exp_rst_q.push_back({1'b1, 32'd33});
      exp_rst_q.push_back({1'b0, 32'd59});
      wait_edge(32); chk("c2_soc_e32", 32'(soc_arst), 32'd0);
      wait_edge(33); chk("c2_soc_e33", 32'(soc_arst), 32'd1);
      wait_edge(40); pll_locked = 1'b1;
      wait_edge(58); chk("c2_soc_e58", 32'(soc_arst), 32'd1);
      wait_edge(59); chk("c2_soc_e59", 32'(soc_arst), 32'd0);

      // case 3: lock glitch while HOLD is at hcnt=10 restarts the hold
      wait_edge(65);
      pll_locked = 1'b0;
      exp_rst_q.push_back({1'b1, 32'd68});
      wait_edge(70); pll_locked = 1'b1;   // HOLD entered at 73
      wait_edge(81); pll_locked = 1'b0;   // seen by FSM at edge 84 (hcnt=10)
      wait_edge(82); pll_locked = 1'b1;
      exp_rst_q.push_back({1'b0, 32'd101});
      wait_edge(89);  chk("c3_no_early", 32'(soc_arst), 32'd1);
      wait_edge(100); chk("c3_soc_e100", 32'(soc_arst), 32'd1);
      wait_edge(101); chk("c3_soc_e101", 32'(soc_arst), 32'd0);

      // case 5: single switch step, then bounced input
      wait_edge(110);
      sw_in = 4'b0001;
      exp_q.push_back({4'b0001, 4'b0001});
      wait_sw(4'b0001, "c5_sw0_rise");
      chk_range("c5_delay", edge_n - 112, 9, 12);
      for (int b = 0; b < 10; b++) begin
         sw_in[0] = 1'b0;
         @(negedge clk);
         sw_in[0] = 1'b1;
         repeat (5) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("c5_bounce_hold", 32'(sw_out), 32'b0001);

      // case 6: all channels step together
      sw_in = 4'b0000;
      exp_q.push_back({4'b0001, 4'b0000});
      wait_sw(4'b0000, "c6_sw_clear");
      @(negedge clk);
      sw_in = 4'b1111;
      exp_q.push_back({4'b1111, 4'b1111});
      wait_sw(4'b1111, "c6_sw_all");
      repeat (2) @(negedge clk);
      chk("c6_chg_one_cycle", 32'(sw_chg), 32'd0);

      // case 4: board reset mid-RUN with sw_o=1010
      sw_in = 4'b1010;
      exp_q.push_back({4'b0101, 4'b1010});
      wait_sw(4'b1010, "c4_sw_1010");
      @(negedge clk);
      #2 arst_n = 1'b0;
      #1;
      chk("c4_async_soc", 32'(soc_arst), 32'd1);
      chk("c4_async_sw_o", 32'(sw_out), 32'd0);
      chk("c4_async_chg", 32'(sw_chg), 32'd0);
      sw_in = '0;
      repeat (3) @(negedge clk);
      exp_rst_q.push_back({1'b0, 32'd19});
      #2 arst_n = 1'b1;
      wait_edge(18); chk("c4_soc_e18", 32'(soc_arst), 32'd1);
      wait_edge(19); chk("c4_soc_e19", 32'(soc_arst), 32'd0);
      chk("c4_sw_o", 32'(sw_out), 32'd0);

      repeat (8) @(negedge clk);
      chk("chg_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("rst_queue_drained", 32'(exp_rst_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/board_io_cond.md
Name: board_io_cond

Overview:
- Parametrised board-level front end placed between FPGA pins/PLL and the sigma SoC instance in each board top.
- Generates a stretched, lock-qualified SoC reset.
- Synchronises and debounces an N-bit switch bank, emitting per-channel change strobes for the SoC GPIO inputs.
- Replaces the direct combinational reset/PLL-lock combination and raw switch wiring used in board tops.

Parameters:
SW_WIDTH, 16, number of switch channels
SYNC_STAGES, 2, flops in each input synchroniser (legal >= 2)
RST_HOLD, 1024, cycles SoC reset is held after lock is seen stable (legal >= 1)
TICK_DIV, 100000, clk cycles per debounce tick (legal >= 2)
DEB_TICKS, 4, consecutive mismatching ticks needed to accept a switch change (legal >= 1)

Ports:
clk_i  in  1  system clock (PLL output)
arst_n_i  in  1  asynchronous active-low reset (board reset button)
pll_locked_i  in  1  PLL lock, asynchronous to clk_i
sw_i  in  SW_WIDTH  raw switch pins
soc_arst_o  out  1  active-high SoC reset, registered
sw_o  out  SW_WIDTH  debounced switch state
sw_chg_o  out  SW_WIDTH  one-cycle pulse per channel when sw_o bit changes
tick_o  out  1  one-cycle debounce tick pulse

Behaviour:
- Decided: one clock; reset asynchronous, active-low on arst_n_i. All flops clear asynchronously when arst_n_i=0.
- Reset values: soc_arst_o=1, sw_o=0, sw_chg_o=0, tick_o=0. Synchronisers, counters and FSM are at 0/RST.
- arst_n_i low forces soc_arst_o high immediately (asynchronous path), not waiting for a clock.
- locked_s: pll_locked_i through SYNC_STAGES flops. sw_s: each sw_i bit through SYNC_STAGES flops.
- Reset FSM, states RST, HOLD, RUN:
  - RST: hcnt=0. Go to HOLD when locked_s=1.
  - HOLD: hcnt+1 per cycle. locked_s=0 goes to RST (hcnt cleared). When hcnt==RST_HOLD-1, go to RUN.
  - RUN: locked_s=0 goes to RST.
- soc_arst_o is registered as (next_state != RUN). It falls on the same edge the FSM enters RUN and rises on the same edge it leaves RUN.
- Latency: with pll_locked_i=1 before reset release and edges counted from 1 after release, soc_arst_o falls at edge SYNC_STAGES+RST_HOLD+1. Lock loss in RUN raises soc_arst_o SYNC_STAGES+1 edges after pll_locked_i falls.
- Tick prescaler: tcnt counts 0..TICK_DIV-1 and wraps. tick_o=1 exactly in the cycle tcnt==TICK_DIV-1. Runs freely; independent of FSM state.
- Per-channel debouncer with dcnt of width clog2(DEB_TICKS+1):
  - If sw_s[i]==sw_o[i]: dcnt=0.
  - Else on tick: if dcnt==DEB_TICKS-1, then sw_o[i] <= sw_s[i], sw_chg_o[i]=1 for that one cycle, dcnt=0; otherwise dcnt+1.
  - Any return to equality before acceptance clears dcnt, so bounces are rejected.
  - Acceptance delay after sw_s changes: between (DEB_TICKS-1)*TICK_DIV+1 and DEB_TICKS*TICK_DIV cycles.
  - Channels are independent; several may pulse sw_chg_o in the same cycle.
- Debouncer is not reset by soc_arst_o, only by arst_n_i, so switch state survives PLL relock.
- Simultaneous events: lock loss on the same edge HOLD would reach RUN gives RST. The mismatch check uses the current-cycle sw_s.

Test Plan:
Params SW_WIDTH=4, SYNC_STAGES=2, RST_HOLD=16, TICK_DIV=4, DEB_TICKS=3 for all cases.
1. pll_locked_i=1, release arst_n_i -> soc_arst_o stays 1 through edge 18, falls at edge 19; sw_o=0, no sw_chg_o.
2. In RUN, drop pll_locked_i for 10 cycles then restore -> soc_arst_o rises 3 edges after the drop; after restore it falls again 2+16+1=19 edges later.
3. In HOLD at hcnt=10, 1-cycle lock glitch (synchronised) -> FSM returns to RST; the full 16-cycle hold restarts, no early deassert.
4. Assert arst_n_i mid-RUN with sw_o=4'b1010 -> soc_arst_o=1 and sw_o=0 without a clock edge; release repeats case 1 timing.
5. sw_i[0] 0->1 held -> sw_o[0] rises 9..12 cycles after sw_s[0] changes, with a single sw_chg_o[0] pulse. A 1-cycle-low bounce every 6 cycles -> sw_o[0] never changes.
6. sw_i=4'b1111 step held -> all four sw_o bits rise in the same cycle; sw_chg_o=4'b1111 for exactly one cycle; tick_o period exactly 4 cycles throughout.
